// File: rtl/led_drv_pkg.sv
// Shared types, mode encodings and the per-LED "lit" decode for the LED pattern driver.
package led_drv_pkg;

  localparam int unsigned NUM_LEDS = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned MODE_W   = 2;
  localparam int unsigned DUTY_W   = 8;

  localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
  localparam logic [MODE_W-1:0] MODE_PWM   = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  // Command payload held between acceptance and the mode-table write
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [MODE_W-1:0] mode;
    logic [DUTY_W-1:0] duty;
  } cmd_t;

  // Active-high "LED lit" for one LED given its mode and the shared timebases
  function automatic logic led_on(input logic [MODE_W-1:0] mode,
                                  input logic [DUTY_W-1:0] duty,
                                  input logic [DUTY_W-1:0] pwm_cnt,
                                  input logic              blink_phase);
    logic on;
    case (mode)
      MODE_OFF:   on = 1'b0;
      MODE_ON:    on = 1'b1;
      MODE_BLINK: on = blink_phase;
      default:    on = (pwm_cnt < duty);
    endcase
    return on;
  endfunction

endpackage

// File: rtl/led_pattern_driver_tick.sv
// Shared prescaler: one-cycle tick every TICK_DIV clocks.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c = (cnt_q == CNT_TERM);

  // Wrap to zero on the terminal count, otherwise count up
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick_c) begin
      cnt_d = '0;
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Drives 4 active-low LEDs (OFF/ON/BLINK/PWM per LED) from handshaked commands.
module led_pattern_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned BLINK_HALF = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IDX_W-1:0]    cmd_idx,
  input  logic [MODE_W-1:0]   cmd_mode,
  input  logic [DUTY_W-1:0]   cmd_duty,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_TERM = BLINK_W'(BLINK_HALF - 1);

  state_e                          state_q, state_d;
  cmd_t                            cmd_q, cmd_d;
  logic                            ready_q, ready_d;
  logic [NUM_LEDS-1:0][MODE_W-1:0] mode_q, mode_d;
  logic [NUM_LEDS-1:0][DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0]               pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]              blink_cnt_q, blink_cnt_d;
  logic                            blink_phase_q, blink_phase_d;
  logic [NUM_LEDS-1:0]             led_out_q, led_out_d;
  logic                            tick_c;

  assign cmd_ready = ready_q;
  assign led_out   = led_out_q;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_c (tick_c)
  );

  // Command FSM: capture in IDLE, write the mode table in APPLY
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    duty_d  = duty_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          cmd_d.idx  = cmd_idx;
          cmd_d.mode = cmd_mode;
          cmd_d.duty = cmd_duty;
          state_d    = ST_APPLY;
        end
      end
      ST_APPLY: begin
        mode_d[cmd_q.idx] = cmd_q.mode;
        if (cmd_q.mode == MODE_PWM) begin
          duty_d[cmd_q.idx] = cmd_q.duty;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Free-running PWM step and blink phase, advanced on each tick
  always_comb begin
    pwm_cnt_d     = pwm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick_c) begin
      pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);
      if (blink_cnt_q == BLINK_TERM) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Per-LED decode from the current mode table and timebases, inverted for active-low drive
  always_comb begin
    led_out_d = '1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_out_d[i] = ~led_on(mode_q[i], duty_q[i], pwm_cnt_q, blink_phase_q);
    end
  end

  // State, mode table, timebase and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      ready_q       <= 1'b1;
      mode_q        <= '0;
      duty_q        <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led_out_q     <= '1;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      ready_q       <= ready_d;
      mode_q        <= mode_d;
      duty_q        <= duty_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_out_q     <= led_out_d;
    end
  end

endmodule
